// File: rtl/konv_serial_capture.sv
// Serial burst receiver: synchronises the burst enable/clock/data, assembles WIDTH-bit frames
// and hands them out through a one-entry valid/ready register. Optional `KONV_FRAME_CNT_EN adds frame_cnt.
module konv_serial_capture #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_en,
  input  logic             ser_clk,
  input  logic             ser_data,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err,
  output logic             overflow,
  input  logic             ovf_clr
`ifdef KONV_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ARMED, CHECK} state_t;

  state_t                   state, state_n;
  logic [SYNC_STAGES-1:0]   en_sync, clk_sync, dat_sync;
  logic                     en_d, clk_d;
  logic [SYNC_STAGES:0]     prime;
  logic                     en_armed;
  logic                     rise_pend, rise_pend_n;
  logic [WIDTH-1:0]         shreg, shreg_n;
  logic [CNT_W-1:0]         bitcnt, bitcnt_n;
  logic [WIDTH-1:0]         word_n;
  logic                     valid_n, ferr_n, ovf_n;
`ifdef KONV_FRAME_CNT_EN
  logic [15:0]              cnt_n;
`endif

  logic en_s, clk_s, dat_s, en_rise, en_fall, clk_rise;

  assign en_s     = en_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign dat_s    = dat_sync[SYNC_STAGES-1];
  // An enable already high when reset lifts must first be seen low before a rise counts
  assign en_rise  = en_s & ~en_d & en_armed;
  assign en_fall  = ~en_s & en_d;
  assign clk_rise = clk_s & ~clk_d;

  // Input synchronisers, edge-detect flops and the post-reset enable qualifier
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sync  <= '0;
      clk_sync <= '0;
      dat_sync <= '0;
      en_d     <= 1'b0;
      clk_d    <= 1'b0;
      prime    <= '0;
      en_armed <= 1'b0;
    end else begin
      en_sync  <= {en_sync[SYNC_STAGES-2:0], ser_en};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ser_data};
      en_d     <= en_s;
      clk_d    <= clk_s;
      prime    <= {prime[SYNC_STAGES-1:0], 1'b1};
      en_armed <= en_armed | (prime[SYNC_STAGES] & ~en_s);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rise_pend  <= 1'b0;
      shreg      <= '0;
      bitcnt     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
`ifdef KONV_FRAME_CNT_EN
      frame_cnt  <= '0;
`endif
    end else begin
      state      <= state_n;
      rise_pend  <= rise_pend_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      word       <= word_n;
      word_valid <= valid_n;
      frame_err  <= ferr_n;
      overflow   <= ovf_n;
`ifdef KONV_FRAME_CNT_EN
      frame_cnt  <= cnt_n;
`endif
    end
  end

  // Next-state, capture and output-register logic
  always_comb begin
    state_n     = state;
    rise_pend_n = rise_pend;
    shreg_n     = shreg;
    bitcnt_n    = bitcnt;
    word_n      = word;
    valid_n     = word_valid;
    ferr_n      = 1'b0;
    ovf_n       = overflow;
`ifdef KONV_FRAME_CNT_EN
    cnt_n       = frame_cnt;
`endif

    if (word_valid && word_ready) valid_n = 1'b0;
    if (ovf_clr) ovf_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (en_rise || rise_pend) begin
          state_n     = ARMED;
          rise_pend_n = 1'b0;
          shreg_n     = '0;
          bitcnt_n    = '0;
        end
      end
      ARMED: begin
        if (clk_rise) begin
          shreg_n = {shreg[WIDTH-2:0], dat_s};
          if (bitcnt != CNT_W'(WIDTH + 1)) bitcnt_n = bitcnt + CNT_W'(1);
        end
        if (en_fall) state_n = CHECK;
      end
      CHECK: begin
        state_n = IDLE;
        if (en_rise) rise_pend_n = 1'b1;
        if (bitcnt == CNT_W'(WIDTH)) begin
          // A word being consumed this cycle frees the register for the new frame
          if (word_valid && !word_ready) begin
            ovf_n = 1'b1;
          end else begin
            word_n  = shreg;
            valid_n = 1'b1;
`ifdef KONV_FRAME_CNT_EN
            cnt_n   = frame_cnt + 16'd1;
`endif
          end
        end else begin
          ferr_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_konv_serial_capture.sv
// Self-checking bench for konv_serial_capture: directed scenarios plus randomised frames
// checked against a frame-level reference model.
module tb_konv_serial_capture;

  localparam int W = 32;
  localparam int S = 2;

  logic          clk, reset;
  logic          ser_en, ser_clk, ser_data;
  logic [W-1:0]  word;
  logic          word_valid, word_ready, frame_err, overflow, ovf_clr;
`ifdef KONV_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int ferr_seen = 0;

  // Frame-level reference model
  logic [W-1:0] m_word;
  logic         m_valid, m_ovf;
  int           m_ferr, m_loads;

  konv_serial_capture #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .ser_en(ser_en), .ser_clk(ser_clk), .ser_data(ser_data),
    .word(word), .word_valid(word_valid), .word_ready(word_ready),
    .frame_err(frame_err), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef KONV_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) ferr_seen++;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_bit(input logic b);
    ser_data = b;
    cyc(4);
    ser_clk = 1'b1;
    cyc(4);
    ser_clk = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [63:0] bits);
    ser_en = 1'b1;
    cyc(5);
    for (int i = 0; i < n; i++) pulse_bit(bits[n-1-i]);
    cyc(4);
    ser_en = 1'b0;
  endtask

  // Outcome of a frame when nothing consumes the word meanwhile
  task automatic model_frame(input int n, input logic [63:0] bits);
    if (n == W) begin
      if (m_valid) m_ovf = 1'b1;
      else begin m_word = bits[W-1:0]; m_valid = 1'b1; m_loads++; end
    end else begin
      m_ferr++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; ser_en = 1'b0; ser_clk = 1'b0; ser_data = 1'b0;
    word_ready = 1'b0; ovf_clr = 1'b0;
    m_word = '0; m_valid = 1'b0; m_ovf = 1'b0; m_ferr = 0; m_loads = 0;
    cyc(3);
    checks++; if (word !== '0) begin failures++; $display("FAIL reset_word got=%h exp=0", word); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    reset = 1'b1;
    cyc(10);
  endtask

  task automatic test_single;
    int lat;
    logic [63:0] d;
    d = 64'hA5C3_0F81;
    word_ready = 1'b1;
    send_frame(W, d);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (word_valid === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat != S + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, S + 2); end
    checks++; if (word !== 32'hA5C3_0F81) begin failures++; $display("FAIL single_word got=%h exp=a5c30f81", word); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL single_ovf got=%b exp=0", overflow); end
    m_word = 32'hA5C3_0F81; m_loads++;
    cyc(4);
    word_ready = 1'b0;
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL single_consumed got=%b exp=0", word_valid); end
    checks++; if (ferr_seen != m_ferr) begin failures++; $display("FAIL single_ferr got=%0d exp=%0d", ferr_seen, m_ferr); end
  endtask

  task automatic test_bad_length;
    logic [63:0] d;
    d = {$urandom, $urandom};
    send_frame(W - 1, d); model_frame(W - 1, d);
    cyc(10);
    d = {$urandom, $urandom};
    send_frame(W + 1, d); model_frame(W + 1, d);
    cyc(10);
    checks++; if (ferr_seen != m_ferr) begin failures++; $display("FAIL badlen_ferr got=%0d exp=%0d", ferr_seen, m_ferr); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL badlen_valid got=%b exp=0", word_valid); end
  endtask

  task automatic test_overflow;
    send_frame(W, 64'h1111_1111); model_frame(W, 64'h1111_1111);
    cyc(10);
    send_frame(W, 64'h2222_2222); model_frame(W, 64'h2222_2222);
    cyc(10);
    checks++; if (word !== m_word) begin failures++; $display("FAIL ovf_word got=%h exp=%h", word, m_word); end
    checks++; if (word_valid !== m_valid) begin failures++; $display("FAIL ovf_valid got=%b exp=%b", word_valid, m_valid); end
    checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", overflow, m_ovf); end
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0; m_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    word_ready = 1'b1; cyc(1); word_ready = 1'b0; m_valid = 1'b0;
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL ovf_consume got=%b exp=0", word_valid); end
    send_frame(W, 64'h3333_3333); model_frame(W, 64'h3333_3333);
    cyc(10);
    checks++; if (word !== 32'h3333_3333) begin failures++; $display("FAIL ovf_next_word got=%h exp=33333333", word); end
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL ovf_next_valid got=%b exp=1", word_valid); end
  endtask

  // Consume the held word in exactly the cycle the next frame is loaded
  task automatic test_back_to_back;
    logic [63:0] d;
    d = {32'h0, $urandom};
    send_frame(W, d);
    cyc(S + 1);
    word_ready = 1'b1;
    cyc(1);
    word_ready = 1'b0;
    m_word = d[W-1:0]; m_valid = 1'b1; m_loads++;
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", word_valid); end
    checks++; if (word !== m_word) begin failures++; $display("FAIL b2b_word got=%h exp=%h", word, m_word); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
    cyc(6);
    checks++; if (word_valid !== 1'b1 || word !== m_word) begin
      failures++; $display("FAIL b2b_hold got=%b/%h exp=1/%h", word_valid, word, m_word); end
  endtask

  task automatic test_reset_midframe;
    int ferr0;
    ser_en = 1'b1;
    cyc(5);
    for (int i = 0; i < 16; i++) pulse_bit(1'($urandom_range(0, 1)));
    ferr0 = ferr_seen;
    reset = 1'b0;
    cyc(2);
    m_word = '0; m_valid = 1'b0; m_ovf = 1'b0; m_loads = 0;
    checks++; if (word !== '0 || word_valid !== 1'b0 || overflow !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL midreset_outputs got=%h/%b/%b/%b exp=0/0/0/0", word, word_valid, overflow, frame_err); end
    reset = 1'b1;
    cyc(10);
    for (int i = 0; i < 5; i++) pulse_bit(1'b1);
    cyc(4);
    ser_en = 1'b0;
    cyc(10);
    checks++; if (ferr_seen != ferr0 || word_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_stale_en got=ferr%0d/v%b exp=ferr%0d/v0", ferr_seen, word_valid, ferr0); end
    send_frame(W, 64'hDEAD_BEEF); model_frame(W, 64'hDEAD_BEEF);
    cyc(10);
    checks++; if (word !== 32'hDEAD_BEEF || word_valid !== 1'b1) begin
      failures++; $display("FAIL midreset_next got=%h/%b exp=deadbeef/1", word, word_valid); end
  endtask

  task automatic test_random;
    int n;
    logic [63:0] d;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        word_ready = 1'b1; cyc(1); word_ready = 1'b0; m_valid = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0; m_ovf = 1'b0;
      end
      case ($urandom_range(0, 4))
        0, 1: n = W;
        2: n = W - 1;
        3: n = W + 1;
        default: n = int'($urandom_range(1, W + 3));
      endcase
      d = {$urandom, $urandom};
      send_frame(n, d); model_frame(n, d);
      cyc(10);
      checks++; if (word !== m_word) begin failures++; $display("FAIL rand%0d_word got=%h exp=%h", it, word, m_word); end
      checks++; if (word_valid !== m_valid) begin failures++; $display("FAIL rand%0d_valid got=%b exp=%b", it, word_valid, m_valid); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rand%0d_ovf got=%b exp=%b", it, overflow, m_ovf); end
      checks++; if (ferr_seen != m_ferr) begin failures++; $display("FAIL rand%0d_ferr got=%0d exp=%0d", it, ferr_seen, m_ferr); end
    end
  endtask

`ifdef KONV_FRAME_CNT_EN
  task automatic test_frame_cnt;
    checks++; if (frame_cnt !== 16'(m_loads)) begin
      failures++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, m_loads); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_bad_length;
    test_overflow;
    test_back_to_back;
    test_reset_midframe;
    test_random;
`ifdef KONV_FRAME_CNT_EN
    test_frame_cnt;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
